// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: walks the select lines of a downstream 8:1 mux,
// holds each select value for DWELL cycles, samples the fed-back mux output
// and presents the eight samples as one word with a one-cycle done pulse.
// Optional feature macro: SCAN_DIR_DOWN_EN (scan channels 7..0 instead of 0..7;
// the bit mapping data_out[k] = sample taken while sel==k is the same either way).
module mux_scan_sequencer #(
    parameter int DWELL = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mux_y,
    output logic [2:0] sel,
    output logic       busy,
    output logic       done,
    output logic [7:0] data_out
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [3:0] RELOAD = 4'(DWELL - 1);

`ifdef SCAN_DIR_DOWN_EN
    localparam logic [2:0] FIRST_CH = 3'd7;
    localparam logic [2:0] LAST_CH  = 3'd0;

    function automatic logic [2:0] next_ch(input logic [2:0] ch);
        return ch - 3'd1;
    endfunction
`else
    localparam logic [2:0] FIRST_CH = 3'd0;
    localparam logic [2:0] LAST_CH  = 3'd7;

    function automatic logic [2:0] next_ch(input logic [2:0] ch);
        return ch + 3'd1;
    endfunction
`endif

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    logic [2:0] sel_next;
    logic [7:0] cap, cap_next;
    logic [7:0] data_next;

    // State and datapath registers; reset aborts any scan without publishing it
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= 3'd0;
            cnt      <= 4'd0;
            cap      <= 8'h00;
            data_out <= 8'h00;
        end else begin
            state    <= state_next;
            sel      <= sel_next;
            cnt      <= cnt_next;
            cap      <= cap_next;
            data_out <= data_next;
        end
    end

    // Next-state, dwell counting, capture and status outputs
    always_comb begin
        state_next = state;
        sel_next   = sel;
        cnt_next   = cnt;
        cap_next   = cap;
        data_next  = data_out;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SCAN;
                    sel_next   = FIRST_CH;
                    cnt_next   = RELOAD;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (cnt == 4'd0) begin
                    cap_next[sel] = mux_y;
                    if (sel == LAST_CH) begin
                        // Publish including the bit captured on this very edge
                        data_next  = cap_next;
                        state_next = DONE;
                        sel_next   = 3'd0;
                    end else begin
                        sel_next = next_ch(sel);
                        cnt_next = RELOAD;
                    end
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (DWELL=1 and DWELL=3) share
// start/rst and the mux pattern a; each sees its own mux output a[sel].
// A timing model predicts sel/busy/done/data_out per cycle; scan completions
// are queued at acceptance and popped by the monitor when done appears.
module tb_mux_scan_sequencer;

    localparam int DW0 = 1;
    localparam int DW1 = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic       mux_y [2];
    logic [2:0] sel   [2];
    logic       busy  [2];
    logic       done  [2];
    logic [7:0] dout  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mux_y[0] = a[sel[0]];
    assign mux_y[1] = a[sel[1]];

    mux_scan_sequencer #(.DWELL(DW0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .mux_y(mux_y[0]),
        .sel(sel[0]), .busy(busy[0]), .done(done[0]), .data_out(dout[0])
    );

    mux_scan_sequencer #(.DWELL(DW1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .mux_y(mux_y[1]),
        .sel(sel[1]), .busy(busy[1]), .done(done[1]), .data_out(dout[1])
    );

    function automatic int dwell_of(input int i);
        return (i == 0) ? DW0 : DW1;
    endfunction

    // k-th channel visited in a scan
    function automatic int chan(input int k);
`ifdef SCAN_DIR_DOWN_EN
        return 7 - k;
`else
        return k;
`endif
    endfunction

    // ---------------- reference model ----------------
    int         edge_n = 0;
    bit         started = 0;
    int         acc     [2] = '{-1, -1};
    int         next_ok [2] = '{0, 0};
    logic [7:0] word    [2] = '{8'h00, 8'h00};
    logic [7:0] exp_dout[2] = '{8'h00, 8'h00};
    int         due_q0[$];
    int         due_q1[$];

    always @(posedge clk) begin
        edge_n++;
        for (int i = 0; i < 2; i++) begin
            int d;
            int j;
            d = dwell_of(i);
            if (rst) begin
                started     = 1;
                acc[i]      = -1;
                next_ok[i]  = edge_n + 1;
                word[i]     = 8'h00;
                exp_dout[i] = 8'h00;
                if (i == 0) due_q0.delete(); else due_q1.delete();
            end else if (started) begin
                if (acc[i] >= 0) begin
                    j = edge_n - acc[i];
                    if (j >= d && j <= 8 * d && (j % d) == 0)
                        word[i][chan(j / d - 1)] = a[chan(j / d - 1)];
                    if (j == 8 * d)
                        exp_dout[i] = word[i];
                end
                if (start && edge_n >= next_ok[i]) begin
                    acc[i]     = edge_n;
                    next_ok[i] = edge_n + 8 * d + 2;
                    if (i == 0) due_q0.push_back(edge_n + 8 * d);
                    else        due_q1.push_back(edge_n + 8 * d);
                end
            end
        end
    end

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] at edge %0d: got %0h, expected %0h", name, i, edge_n, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                int  d;
                int  j;
                bit  in_scan;
                bit  exp_done;
                int  exp_sel;
                int  due;
                d        = dwell_of(i);
                j        = (acc[i] >= 0) ? edge_n - acc[i] : -1;
                in_scan  = (j >= 0) && (j < 8 * d);
                exp_done = (j == 8 * d);
                exp_sel  = in_scan ? chan(j / d) : 0;
                chk("sel",      i, 32'(sel[i]),  32'(exp_sel));
                chk("busy",     i, 32'(busy[i]), 32'(in_scan));
                chk("done",     i, 32'(done[i]), 32'(exp_done));
                chk("data_out", i, 32'(dout[i]), 32'(exp_dout[i]));
                if (done[i] === 1'b1) begin
                    if ((i == 0 ? due_q0.size() : due_q1.size()) == 0) begin
                        chk("unexpected_done", i, 32'd1, 32'd0);
                    end else begin
                        due = (i == 0) ? due_q0.pop_front() : due_q1.pop_front();
                        chk("done_edge", i, 32'(edge_n), 32'(due));
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((busy[0] || busy[1] || done[0] || done[1]) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) chk("idle_timeout", 0, 32'd1, 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_done0(input int limit);
        int n = 0;
        @(negedge clk);
        while (done[0] !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) chk("done_timeout", 0, 32'd1, 32'd0);
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // single scans with a fixed pattern
        a = 8'h0A;
        pulse_start();
        wait_idle(100);
        a = 8'hA5;
        pulse_start();
        wait_idle(100);

        // reset in the middle of a scan (instance 1 at sel==4)
        a = 8'hFF;
        pulse_start();
        n = 0;
        while (sel[1] !== 3'd4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("sel4_timeout", 1, 32'd1, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // start held: back-to-back scans, pattern changes after first done
        a     = 8'h3C;
        start = 1'b1;
        wait_done0(100);
        a = 8'hC3;
        wait_done0(100);
        start = 1'b0;
        wait_idle(100);

        // extra start pulses during a scan are ignored
        a = 8'h5A;
        pulse_start();
        repeat (3) @(negedge clk);
        pulse_start();
        @(negedge clk);
        pulse_start();
        wait_idle(100);

        // randomized traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            start = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 2) == 0) a = 8'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        rst   = 1'b0;
        wait_idle(100);

        chk("pending_q", 0, 32'(due_q0.size()), 32'd0);
        chk("pending_q", 1, 32'(due_q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_scan_sequencer.md
MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 Parameter DWELL, default 1, SHALL set the number of clk cycles each select value is held before sampling; the legal range is 1..15.
REQ-003 Port clk, input, 1 bit, SHALL be the rising-edge clock for all state.
REQ-004 Port rst, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-005 Port start, input, 1 bit, SHALL be a scan request, sampled only in IDLE.
REQ-006 Port mux_y, input, 1 bit, SHALL be the output of the downstream 8:1 mux, fed back for sampling.
REQ-007 Port sel, output, 3 bits, SHALL drive the select input of the 8:1 mux.
REQ-008 Port busy, output, 1 bit, SHALL be high while a scan is in progress.
REQ-009 Port done, output, 1 bit, SHALL be a one-cycle pulse when a scan completes.
REQ-010 Port data_out, output, 8 bits, SHALL hold the captured word; data_out[k] is the value of mux_y sampled while sel==k.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-012 In IDLE, when start is high at an edge (edge 0), the block SHALL enter SCAN with sel=first channel, the dwell counter set to DWELL-1 and busy=1.
REQ-013 In SCAN, the dwell counter SHALL decrement each cycle; at the edge where it equals 0, mux_y SHALL be captured into capture bit sel.
REQ-014 After that capture, if sel is not the last channel, sel SHALL step to the next channel and the counter SHALL reload to DWELL-1.
REQ-015 Channel scanned k-th (k=0..7) SHALL be captured at edge (k+1)*DWELL after edge 0.
REQ-016 At edge 8*DWELL, the full capture word SHALL be copied to data_out, including the final bit captured at that edge. At the same edge the FSM SHALL enter DONE with done=1, busy=0 and sel=0.
REQ-017 DONE SHALL last exactly one cycle and then return to IDLE; done SHALL be 0 in every other state.
REQ-018 data_out SHALL change only at the completion edge and SHALL hold its value until the next completion.
REQ-019 start SHALL be ignored while in SCAN or DONE; there is no queuing of requests.
REQ-020 start held high continuously SHALL begin a new scan on the first IDLE cycle after DONE, giving back-to-back scans with one IDLE cycle between them.
REQ-021 sel SHALL be 0 in IDLE.

Reset
REQ-022 When rst is high at an edge, the block SHALL go to IDLE with sel=0, busy=0, done=0, data_out=8'h00, counter=0 and capture register=0.
REQ-023 Reset SHALL take priority over start and over any in-progress scan. A scan aborted by reset SHALL NOT assert done and SHALL NOT update data_out.

Configuration
REQ-024 Macro SCAN_DIR_DOWN_EN SHALL select the scan order.
REQ-025 When SCAN_DIR_DOWN_EN is undefined, the first channel SHALL be 0, the last SHALL be 7, and sel SHALL increment.
REQ-026 When SCAN_DIR_DOWN_EN is defined, the first channel SHALL be 7, the last SHALL be 0, and sel SHALL decrement. The bit mapping data_out[k] = sample at sel==k SHALL be unchanged.
REQ-027 Scan timing and the done pulse SHALL be identical in both configurations.

Verification
REQ-028 With DWELL=1, mux a=8'b0000_1010 and start pulsed for one cycle: sel SHALL step 0..7 on consecutive cycles, done SHALL pulse at edge 8, and data_out SHALL be 8'h0A.
REQ-029 With DWELL=3 and a=8'hA5: each sel value SHALL be held 3 cycles, done SHALL occur at edge 24, and data_out SHALL be 8'hA5.
REQ-030 With rst asserted for one cycle while sel==4 mid-scan: sel SHALL be 0, busy SHALL be 0, done SHALL never pulse, and data_out SHALL be 8'h00.
REQ-031 With start held high, a=8'h3C then changed to 8'hC3 after the first done: there SHALL be two scans separated by one IDLE cycle, with data_out equal to 8'h3C and then 8'hC3.
REQ-032 With start pulsed again during SCAN: there SHALL be no effect, and exactly one done SHALL be produced.
REQ-033 With SCAN_DIR_DOWN_EN defined, DWELL=1 and a=8'h0A: sel SHALL run 7..0, and data_out SHALL be 8'h0A at edge 8.
